// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised register file with pending-write scoreboard and flash-clear engine
// Optional REG_FILE_BYPASS_EN: same-cycle write-to-read forwarding on both read ports.
module reg_file_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] raddrA,
  input  logic [ADDR_W-1:0] raddrB,
  output logic [DATA_W-1:0] data_outA,
  output logic [DATA_W-1:0] data_outB,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              pend_A,
  output logic              pend_B,
  input  logic              clear_req,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]    pend, pend_nxt;
  logic                wr_acc;
  logic                pend_acc;

  // Writes and scoreboard sets aimed at a hardwired-zero r0 are discarded here.
  assign wr_acc   = RegWrite && (state == IDLE) &&
                    !((ZERO_REG != 0) && (write_register == '0));
  assign pend_acc = pend_set && (state == IDLE) &&
                    !((ZERO_REG != 0) && (pend_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (ptr == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
    end else if (clear_req) begin
      ptr <= '0;
    end
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[ptr] <= '0;
    end else if (wr_acc) begin
      regs[write_register] <= data_in;
    end
  end

  // A retiring write and a new producer on the same register leave it pending.
  always_comb begin
    pend_nxt = pend;
    if (state == IDLE) begin
      if (clear_req) begin
        pend_nxt = '0;
      end else begin
        if (wr_acc)   pend_nxt[write_register] = 1'b0;
        if (pend_acc) pend_nxt[pend_addr]      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  assign pend_A = pend[raddrA];
  assign pend_B = pend[raddrB];

  always_comb begin
    data_outA = regs[raddrA];
    if ((ZERO_REG != 0) && (raddrA == '0)) data_outA = '0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_acc && (raddrA == write_register)) data_outA = data_in;
`endif
  end

  always_comb begin
    data_outB = regs[raddrB];
    if ((ZERO_REG != 0) && (raddrB == '0)) data_outB = '0;
`ifdef REG_FILE_BYPASS_EN
    if (wr_acc && (raddrB == write_register)) data_outB = data_in;
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard-driven directed bench for reg_file_sb
// Drives a ZERO_REG=0 and a ZERO_REG=1 instance from the same stimulus.
module tb_reg_file_sb;

  logic       clk;
  logic       rst_n;
  logic       RegWrite;
  logic [3:0] write_register;
  logic [7:0] data_in;
  logic [3:0] raddrA, raddrB;
  logic       pend_set;
  logic [3:0] pend_addr;
  logic       clear_req;

  logic [7:0] data_outA, data_outB, z_data_outA, z_data_outB;
  logic       pend_A, pend_B, busy, z_pend_A, z_pend_B, z_busy;

  int checks = 0;
  int errors = 0;
  int nbusy;
  logic [7:0] e8;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_register(write_register),
    .data_in(data_in), .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(data_outA), .data_outB(data_outB),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_A(pend_A), .pend_B(pend_B),
    .clear_req(clear_req), .busy(busy)
  );

  reg_file_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .write_register(write_register),
    .data_in(data_in), .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(z_data_outA), .data_outB(z_data_outB),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_A(z_pend_A), .pend_B(z_pend_B),
    .clear_req(clear_req), .busy(z_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%0h expected=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0; pend_set = 1'b0; clear_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; idle_inputs();
    write_register = '0; data_in = '0; raddrA = '0; raddrB = '0; pend_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state across every address
    push("rst_busy", 0); push("rst_busy_z", 0);
    #1; pop_chk(busy); pop_chk(z_busy);
    for (int a = 0; a < 16; a++) begin
      raddrA = 4'(a); raddrB = 4'(15 - a);
      push("rst_da", 0); push("rst_db", 0); push("rst_pa", 0); push("rst_pb", 0);
      #1; pop_chk(data_outA); pop_chk(data_outB); pop_chk(pend_A); pop_chk(pend_B);
    end

    // Write 0xA5 to r3: same-cycle and next-cycle reads
    @(negedge clk);
    RegWrite = 1'b1; write_register = 4'd3; data_in = 8'hA5; raddrA = 4'd3;
`ifdef REG_FILE_BYPASS_EN
    push("same_cycle_r3", 8'hA5);
`else
    push("same_cycle_r3", 8'h00);
`endif
    #1; pop_chk(data_outA);
    @(negedge clk);
    idle_inputs();
    push("next_cycle_r3", 8'hA5); push("next_cycle_r3_z", 8'hA5);
    #1; pop_chk(data_outA); pop_chk(z_data_outA);

    // r0 write 0xFF with pend_set on r0
    @(negedge clk);
    RegWrite = 1'b1; write_register = 4'd0; data_in = 8'hFF;
    pend_set = 1'b1; pend_addr = 4'd0; raddrA = 4'd0;
    push("z_r0_same_cycle", 8'h00);
    #1; pop_chk(z_data_outA);
    @(negedge clk);
    idle_inputs();
    push("r0_data", 8'hFF); push("r0_pend", 1); push("z_r0_data", 8'h00); push("z_r0_pend", 0);
    #1; pop_chk(data_outA); pop_chk(pend_A); pop_chk(z_data_outA); pop_chk(z_pend_A);

    // Scoreboard sequences on r5/r6
    @(negedge clk);
    pend_set = 1'b1; pend_addr = 4'd5; raddrA = 4'd5; raddrB = 4'd6;
    push("pend5_same_cycle", 0);
    #1; pop_chk(pend_A);
    @(negedge clk);
    idle_inputs();
    push("pend5_set", 1);
    #1; pop_chk(pend_A);
    pend_set = 1'b1; pend_addr = 4'd5; RegWrite = 1'b1; write_register = 4'd5; data_in = 8'h55;
    @(negedge clk);
    idle_inputs();
    push("pend5_set_wins", 1);
    #1; pop_chk(pend_A);
    RegWrite = 1'b1; write_register = 4'd5; data_in = 8'h56;
    @(negedge clk);
    idle_inputs();
    push("pend5_write_clears", 0); push("r5_data", 8'h56);
    #1; pop_chk(pend_A); pop_chk(data_outA);
    pend_set = 1'b1; pend_addr = 4'd6; RegWrite = 1'b1; write_register = 4'd5; data_in = 8'h57;
    @(negedge clk);
    idle_inputs();
    push("pend6_set_split", 1); push("pend5_split", 0);
    #1; pop_chk(pend_B); pop_chk(pend_A);
    pend_set = 1'b1; pend_addr = 4'd5; RegWrite = 1'b1; write_register = 4'd6; data_in = 8'h66;
    @(negedge clk);
    idle_inputs();
    push("pend5_set_split", 1); push("pend6_write_split", 0);
    #1; pop_chk(pend_A); pop_chk(pend_B);

    // Fill r1..r15 with 0x11..0x1F, then mark r12 pending
    for (int i = 1; i < 16; i++) begin
      RegWrite = 1'b1; write_register = 4'(i); data_in = 8'(16 + i);
      @(negedge clk);
    end
    idle_inputs();
    pend_set = 1'b1; pend_addr = 4'd12;
    @(negedge clk);
    idle_inputs();
    raddrA = 4'd12;
    push("pend12_before_clear", 1); push("r12_before_clear", 8'h1C);
    #1; pop_chk(pend_A);
    raddrB = 4'd12; #1; pop_chk(data_outB);

    // Flash clear: 16 busy cycles, partial contents, dropped inputs
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    push("clear_entry_pend12", 0);
    #1; pop_chk(pend_A);
    nbusy = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      nbusy++;
      idle_inputs();
      if (k < 16) begin
        if (k > 0) begin
          raddrA = 4'(k - 1);
          push("clr_below_ptr", 0);
          #1; pop_chk(data_outA);
        end
        raddrB = (k >= 14) ? 4'd15 : 4'(k);
        e8 = (k >= 14) ? 8'h1F : (k == 0) ? 8'hFF : 8'(16 + k);
        push("clr_above_ptr", e8);
        #1; pop_chk(data_outB);
      end
      if (k == 13) begin RegWrite = 1'b1; write_register = 4'd15; data_in = 8'hEE; end
      if (k == 5) begin pend_set = 1'b1; pend_addr = 4'd9; end
      if (k == 8) clear_req = 1'b1;
      @(negedge clk);
    end
    idle_inputs();
    push("busy_cycles", 16);
    pop_chk(nbusy);
    for (int a = 0; a < 16; a++) begin
      raddrA = 4'(a); raddrB = 4'(a);
      push("post_clear_data", 0); push("post_clear_pend", 0);
      #1; pop_chk(data_outA); pop_chk(pend_B);
    end

    // Reset asserted at ptr=7 during a clear
    RegWrite = 1'b1; write_register = 4'd2; data_in = 8'h22;
    @(negedge clk);
    write_register = 4'd12; data_in = 8'hCC;
    @(negedge clk);
    idle_inputs();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (7) @(negedge clk);
    raddrA = 4'd2; raddrB = 4'd12;
    push("mid_r2_cleared", 0); push("mid_r12_old", 8'hCC); push("mid_busy", 1);
    #1; pop_chk(data_outA); pop_chk(data_outB); pop_chk(busy);
    rst_n = 1'b0;
    push("rst_mid_busy", 0); push("rst_mid_r12", 0); push("rst_mid_pend", 0);
    #1; pop_chk(busy); pop_chk(data_outB); pop_chk(pend_B);
    @(negedge clk);
    rst_n = 1'b1;
    push("release_busy", 0);
    #1; pop_chk(busy);
    RegWrite = 1'b1; write_register = 4'd4; data_in = 8'h44;
    @(negedge clk);
    idle_inputs();
    raddrA = 4'd4;
    push("post_reset_write", 8'h44); push("post_reset_busy", 0);
    #1; pop_chk(data_outA); pop_chk(busy);
    @(negedge clk);
    push("post_reset_still_idle", 0);
    #1; pop_chk(busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
